// File: rtl/wb_stream_mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_mbox_pkg
// Brief   : Register offsets, field positions and shared types for the mailbox
// Revision: 1.0
// ============================================================================
package wb_mbox_pkg;

    // Register index as decoded from byte address bits [3:2]
    localparam logic [1:0] MBOX_TXDATA = 2'd0;
    localparam logic [1:0] MBOX_RXDATA = 2'd1;
    localparam logic [1:0] MBOX_STATUS = 2'd2;
    localparam logic [1:0] MBOX_CTRL   = 2'd3;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_RX_FULL  = 2;
    localparam int STAT_RX_EMPTY = 3;
    localparam int STAT_TX_LVL   = 8;
    localparam int STAT_RX_LVL   = 16;

    localparam int CTRL_TX_FLUSH = 0;
    localparam int CTRL_RX_FLUSH = 1;
    localparam int CTRL_IRQ_EN   = 2;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_DIR   = 3'd1,
        ERR_SEL   = 3'd2,
        ERR_FULL  = 3'd3,
        ERR_EMPTY = 3'd4
    } access_err_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } bus_state_e;

endpackage : wb_mbox_pkg
`default_nettype wire

// File: rtl/wb_stream_mailbox_if.sv
`default_nettype none
// ============================================================================
// Module  : wb_stream_mailbox_if
// Brief   : Wishbone B3 classic slave-port signal bundle
// Revision: 1.0
// ============================================================================
interface wb_stream_mailbox_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic [31:0] wb_dat_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
    );
endinterface : wb_stream_mailbox_if
`default_nettype wire

// File: rtl/wb_stream_mailbox_fifo.sv
`default_nettype none
// ============================================================================
// Module  : mbox_fifo
// Brief   : Synchronous first-word-fall-through FIFO with flush and level
// Revision: 1.0
// ============================================================================
module mbox_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_data,
    input  wire logic                       i_pop,
    input  wire logic                       i_flush,
    output logic      [WIDTH-1:0]           o_data,
    output logic                            o_full,
    output logic                            o_empty,
    output logic      [$clog2(DEPTH):0]     o_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    // A full FIFO still accepts a push when a pop frees the slot in the same cycle
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + LVL_W'(w_do_push) - LVL_W'(w_do_pop);
        end
    end
endmodule : mbox_fifo
`default_nettype wire

// File: rtl/wb_stream_mailbox.sv
`default_nettype none
// ============================================================================
// Module  : wb_stream_mailbox
// Brief   : Wishbone classic slave bridging bus software to TX/RX 32-bit streams
// Revision: 1.0
// ============================================================================
module wb_stream_mailbox
    import wb_mbox_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire logic                wb_clk_i,
    input  wire logic                wb_rst_i,
    wb_stream_mailbox_if.slave       wb,
    output logic      [31:0]         m_tdata,
    output logic                     m_tvalid,
    input  wire logic                m_tready,
    input  wire logic [31:0]         s_tdata,
    input  wire logic                s_tvalid,
    output logic                     s_tready,
    output logic                     irq_o
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    bus_state_e       r_state;
    logic             r_ack;
    logic             r_err;
    logic [31:0]      r_dat;
    logic             r_irq_en;

    logic             w_req;
    logic [1:0]       w_addr;
    access_err_e      w_err_code;
    logic             w_ok;
    logic             w_tx_push;
    logic             w_tx_pop;
    logic             w_tx_flush;
    logic             w_rx_push;
    logic             w_rx_pop;
    logic             w_rx_flush;
    logic             w_ctrl_wr;
    logic [31:0]      w_status;
    logic [31:0]      w_rd_data;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic [LVL_W-1:0] w_tx_level;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic [LVL_W-1:0] w_rx_level;
    logic [31:0]      w_rx_head;
    logic             w_unused_bits;

    assign w_unused_bits = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_cti_i, wb.wb_bte_i};

    assign w_req  = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack & ~r_err;
    assign w_addr = wb.wb_adr_i[3:2];

    assign w_tx_pop  = m_tvalid & m_tready;
    assign w_rx_push = s_tvalid & s_tready;

    always_comb begin
        w_err_code = ERR_NONE;
        case (w_addr)
            MBOX_TXDATA: begin
                if (!wb.wb_we_i)                  w_err_code = ERR_DIR;
                else if (wb.wb_sel_i != 4'hF)     w_err_code = ERR_SEL;
                else if (w_tx_full && !w_tx_pop)  w_err_code = ERR_FULL;
            end
            MBOX_RXDATA: begin
                if (wb.wb_we_i)                   w_err_code = ERR_DIR;
                else if (w_rx_empty)              w_err_code = ERR_EMPTY;
            end
            MBOX_STATUS: begin
                if (wb.wb_we_i)                   w_err_code = ERR_DIR;
            end
            MBOX_CTRL: begin
                if (wb.wb_we_i && wb.wb_sel_i != 4'hF) w_err_code = ERR_SEL;
            end
            default: w_err_code = ERR_NONE;
        endcase
    end

    // Side effects are gated by w_ok so an errored access never changes state
    assign w_ok       = w_req & (w_err_code == ERR_NONE);
    assign w_tx_push  = w_ok & (w_addr == MBOX_TXDATA);
    assign w_rx_pop   = w_ok & (w_addr == MBOX_RXDATA);
    assign w_ctrl_wr  = w_ok & (w_addr == MBOX_CTRL) & wb.wb_we_i;
    assign w_tx_flush = w_ctrl_wr & wb.wb_dat_i[CTRL_TX_FLUSH];
    assign w_rx_flush = w_ctrl_wr & wb.wb_dat_i[CTRL_RX_FLUSH];

    always_comb begin
        w_status                          = '0;
        w_status[STAT_TX_FULL]            = w_tx_full;
        w_status[STAT_TX_EMPTY]           = w_tx_empty;
        w_status[STAT_RX_FULL]            = w_rx_full;
        w_status[STAT_RX_EMPTY]           = w_rx_empty;
        w_status[STAT_TX_LVL +: LVL_W]    = w_tx_level;
        w_status[STAT_RX_LVL +: LVL_W]    = w_rx_level;
    end

    always_comb begin
        w_rd_data = '0;
        if (w_ok && !wb.wb_we_i) begin
            case (w_addr)
                MBOX_RXDATA: w_rd_data = w_rx_head;
                MBOX_STATUS: w_rd_data = w_status;
                MBOX_CTRL:   w_rd_data = {29'b0, r_irq_en, 2'b00};
                default:     w_rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_ack   <= w_ok;
                        r_err   <= ~w_ok;
                        r_dat   <= w_rd_data;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_dat   <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_irq_en <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_irq_en <= wb.wb_dat_i[CTRL_IRQ_EN];
        end
    end

    mbox_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_push  (w_tx_push),
        .i_data  (wb.wb_dat_i),
        .i_pop   (w_tx_pop),
        .i_flush (w_tx_flush),
        .o_data  (m_tdata),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_level (w_tx_level)
    );

    mbox_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_push  (w_rx_push),
        .i_data  (s_tdata),
        .i_pop   (w_rx_pop),
        .i_flush (w_rx_flush),
        .o_data  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_level (w_rx_level)
    );

    assign m_tvalid    = ~w_tx_empty;
    assign s_tready    = ~w_rx_full & ~wb_rst_i;
    assign irq_o       = r_irq_en & ~w_rx_empty;

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_err_o = r_err;
    assign wb.wb_rty_o = 1'b0;
    assign wb.wb_dat_o = r_dat;
endmodule : wb_stream_mailbox
`default_nettype wire

// File: tb/tb_wb_stream_mailbox.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_stream_mailbox
// Brief   : Scoreboard bench for the Wishbone stream mailbox
// Revision: 1.0
// ============================================================================
module tb_wb_stream_mailbox;
    import wb_mbox_pkg::*;

    typedef struct {
        bit          exp_err;
        logic [31:0] exp_dat;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        irq_o;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;
    exp_t sb_q[$];

    wb_stream_mailbox_if wb_bus ();

    wb_stream_mailbox #(.DEPTH(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (wb_bus.slave),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .irq_o    (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; returns at a negedge after the response cycle
    task automatic wb_xfer(input bit we, input logic [1:0] reg_idx, input logic [31:0] dat,
                           input logic [3:0] sel, input bit exp_err, input logic [31:0] exp_dat,
                           input string name);
        exp_t e;
        bit   done;
        wb_bus.wb_adr_i = {28'h0, reg_idx, 2'b00};
        wb_bus.wb_dat_i = dat;
        wb_bus.wb_sel_i = sel;
        wb_bus.wb_we_i  = we;
        wb_bus.wb_cyc_i = 1'b1;
        wb_bus.wb_stb_i = 1'b1;
        e.exp_err = exp_err;
        e.exp_dat = exp_dat;
        e.name    = name;
        sb_q.push_back(e);
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(posedge clk);
            #1;
            if (wb_bus.wb_ack_o || wb_bus.wb_err_o) done = 1'b1;
        end
        wb_bus.wb_cyc_i = 1'b0;
        wb_bus.wb_stb_i = 1'b0;
        wb_bus.wb_we_i  = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s: no response within 8 cycles", name);
            e = sb_q.pop_back();
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d, input bit exp_err, input string n);
        wb_xfer(1'b1, r, d, 4'hF, exp_err, 32'h0, n);
    endtask

    task automatic rd(input logic [1:0] r, input bit exp_err, input logic [31:0] exp_d, input string n);
        wb_xfer(1'b0, r, 32'h0, 4'hF, exp_err, exp_d, n);
    endtask

    // Response monitor: pops the scoreboard whenever the DUT acks or errs
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (wb_bus.wb_ack_o || wb_bus.wb_err_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got ack=%b err=%b, expected none",
                             wb_bus.wb_ack_o, wb_bus.wb_err_o);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_resp"}, {30'b0, wb_bus.wb_ack_o, wb_bus.wb_err_o},
                          e.exp_err ? 32'd1 : 32'd2);
                    check(e.name, wb_bus.wb_dat_o, e.exp_dat);
                end
            end else begin
                check("idle_dat_o", wb_bus.wb_dat_o, 32'h0);
            end
        end
    end

    initial begin
        rst             = 1'b1;
        m_tready        = 1'b0;
        s_tdata         = '0;
        s_tvalid        = 1'b0;
        wb_bus.wb_adr_i = '0;
        wb_bus.wb_dat_i = '0;
        wb_bus.wb_sel_i = '0;
        wb_bus.wb_we_i  = 1'b0;
        wb_bus.wb_cyc_i = 1'b0;
        wb_bus.wb_stb_i = 1'b0;
        wb_bus.wb_cti_i = '0;
        wb_bus.wb_bte_i = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'b0, wb_bus.wb_ack_o}, 32'd0);
        check("rst_m_tvalid", {31'b0, m_tvalid}, 32'd0);
        check("rst_s_tready", {31'b0, s_tready}, 32'd0);
        check("rst_irq", {31'b0, irq_o}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("post_rst_s_tready", {31'b0, s_tready}, 32'd1);

        // 1: single TX write
        wr(MBOX_TXDATA, 32'hA5A5_0001, 1'b0, "t1_wr");
        check("t1_m_tvalid", {31'b0, m_tvalid}, 32'd1);
        check("t1_m_tdata", m_tdata, 32'hA5A5_0001);
        rd(MBOX_STATUS, 1'b0, 32'h0000_0108, "t1_status");
        m_tready = 1'b1;
        @(negedge clk);
        m_tready = 1'b0;
        check("t1_drained", {31'b0, m_tvalid}, 32'd0);

        // 2: fill TX to DEPTH, overflow, drain in order
        for (int i = 0; i < 8; i++) wr(MBOX_TXDATA, 32'h100 + i, 1'b0, "t2_wr");
        wr(MBOX_TXDATA, 32'hDEAD, 1'b1, "t2_wr_full");
        rd(MBOX_STATUS, 1'b0, 32'h0000_0809, "t2_status");
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t2_m_tvalid", {31'b0, m_tvalid}, 32'd1);
            check("t2_m_tdata", m_tdata, 32'h100 + i);
            @(negedge clk);
        end
        check("t2_empty", {31'b0, m_tvalid}, 32'd0);
        m_tready = 1'b0;

        // 3: RX words, interrupt, reads, underflow
        s_tvalid = 1'b1;
        s_tdata  = 32'h11;
        @(negedge clk);
        s_tdata  = 32'h22;
        @(negedge clk);
        s_tvalid = 1'b0;
        rd(MBOX_STATUS, 1'b0, 32'h0002_0002, "t3_status");
        check("t3_irq_off", {31'b0, irq_o}, 32'd0);
        wr(MBOX_CTRL, 32'h4, 1'b0, "t3_irq_en");
        check("t3_irq_on", {31'b0, irq_o}, 32'd1);
        rd(MBOX_RXDATA, 1'b0, 32'h11, "t3_rd0");
        rd(MBOX_RXDATA, 1'b0, 32'h22, "t3_rd1");
        rd(MBOX_RXDATA, 1'b1, 32'h0, "t3_rd_empty");
        check("t3_irq_clear", {31'b0, irq_o}, 32'd0);

        // 4: RX full, pop with stream still offering
        s_tvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_tdata = 32'h40 + i;
            @(negedge clk);
        end
        s_tdata = 32'h99;
        check("t4_s_tready_full", {31'b0, s_tready}, 32'd0);
        rd(MBOX_STATUS, 1'b0, 32'h0008_0006, "t4_status_full");
        rd(MBOX_RXDATA, 1'b0, 32'h40, "t4_pop");
        @(negedge clk);
        s_tvalid = 1'b0;
        check("t4_refilled", {31'b0, s_tready}, 32'd0);
        rd(MBOX_STATUS, 1'b0, 32'h0008_0006, "t4_status_refill");
        for (int i = 1; i < 8; i++) rd(MBOX_RXDATA, 1'b0, 32'h40 + i, "t4_rd");
        rd(MBOX_RXDATA, 1'b0, 32'h99, "t4_rd_last");

        // 5: TX flush racing a TX handshake
        for (int i = 0; i < 3; i++) wr(MBOX_TXDATA, 32'hC1 + i, 1'b0, "t5_wr");
        m_tready = 1'b1;
        wr(MBOX_CTRL, 32'h1, 1'b0, "t5_flush");
        check("t5_m_tvalid", {31'b0, m_tvalid}, 32'd0);
        m_tready = 1'b0;
        rd(MBOX_STATUS, 1'b0, 32'h0000_000A, "t5_status");
        rd(MBOX_CTRL, 1'b0, 32'h0, "t5_ctrl");
        wr(MBOX_CTRL, 32'h7, 1'b0, "t5_ctrl_wr");
        rd(MBOX_CTRL, 1'b0, 32'h4, "t5_ctrl_rd");

        // 6: access errors, then reset mid-transfer
        wb_xfer(1'b1, MBOX_TXDATA, 32'hBAD, 4'h3, 1'b1, 32'h0, "t6_sel_err");
        wb_xfer(1'b1, MBOX_CTRL, 32'h0, 4'h1, 1'b1, 32'h0, "t6_ctrl_sel_err");
        rd(MBOX_TXDATA, 1'b1, 32'h0, "t6_rd_tx");
        wr(MBOX_RXDATA, 32'h1, 1'b1, "t6_wr_rx");
        wr(MBOX_STATUS, 32'h1, 1'b1, "t6_wr_status");
        rd(MBOX_STATUS, 1'b0, 32'h0000_000A, "t6_status");
        rd(MBOX_CTRL, 1'b0, 32'h4, "t6_ctrl_kept");
        wr(MBOX_TXDATA, 32'hE1, 1'b0, "t6_wr");
        wr(MBOX_TXDATA, 32'hE2, 1'b0, "t6_wr");
        s_tvalid = 1'b1;
        s_tdata  = 32'h77;
        @(negedge clk);
        s_tvalid = 1'b0;
        check("t6_irq_pre", {31'b0, irq_o}, 32'd1);
        wb_bus.wb_adr_i = {28'h0, MBOX_STATUS, 2'b00};
        wb_bus.wb_we_i  = 1'b0;
        wb_bus.wb_cyc_i = 1'b1;
        wb_bus.wb_stb_i = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_ack", {30'b0, wb_bus.wb_ack_o, wb_bus.wb_err_o}, 32'd0);
        check("t6_rst_m_tvalid", {31'b0, m_tvalid}, 32'd0);
        check("t6_rst_irq", {31'b0, irq_o}, 32'd0);
        check("t6_rst_s_tready", {31'b0, s_tready}, 32'd0);
        @(negedge clk);
        wb_bus.wb_cyc_i = 1'b0;
        wb_bus.wb_stb_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(MBOX_STATUS, 1'b0, 32'h0000_000A, "t6_status_rst");
        rd(MBOX_CTRL, 1'b0, 32'h0, "t6_ctrl_rst");

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule : tb_wb_stream_mailbox
`default_nettype wire
